// File: rtl/clock_pkg.sv
// Shared definitions for the count_up stopwatch: FSM state type,
// seconds width, day wrap point and default prescaler length.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int              SEC_W            = 17;
    localparam logic [SEC_W-1:0] DAY_MAX_SEC     = 17'd86399;
    localparam logic [31:0]     FULL_SEC_DEFAULT = 32'd50000000;

    // Next seconds value on a tick; in free-run the count wraps after one day.
    function automatic logic [SEC_W-1:0] sec_inc(input logic [SEC_W-1:0] sec,
                                                 input logic             free_run);
        if (free_run && (sec == DAY_MAX_SEC)) begin
            return '0;
        end
        return sec + 1'b1;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for an active-low push button plus a falling-edge
// detector; press is a one-cycle pulse on the synchronized 1->0 transition.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    // Synchronizer chain and previous-level register; reset to released (1).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= btn_n;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign press = prev_reg & ~sync2_reg;

endmodule

// File: rtl/count_up.sv
// Seconds stopwatch with optional target stop time and DONE blink.
// Optional lap (split hold) feature is built only when COUNT_UP_LAP_EN is
// defined; otherwise the lap pin is accepted but ignored.
module count_up
    import clock_pkg::*;
#(
    parameter logic [31:0] FULL_SEC = FULL_SEC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             lap,
    input  logic [SEC_W-1:0] target,
    output logic [SEC_W-1:0] c_out,
    output logic             done,
    output logic             blink_hr_sig,
    output logic             blink_min_sig,
    output logic             blink_sec_sig
);

    logic ss_press;
    logic lap_press_raw;
    logic lap_press;

    btn_edge u_ss_edge (
        .clk   (clk),
        .rst   (rst),
        .btn_n (start_stop),
        .press (ss_press)
    );

    btn_edge u_lap_edge (
        .clk   (clk),
        .rst   (rst),
        .btn_n (lap),
        .press (lap_press_raw)
    );

`ifdef COUNT_UP_LAP_EN
    // start_stop wins when both presses land in the same cycle.
    assign lap_press = lap_press_raw & ~ss_press;
`else
    logic unused_lap;
    assign unused_lap = lap_press_raw;
    assign lap_press  = 1'b0;
`endif

    state_t           state_reg, state_next;
    logic [31:0]      presc_reg, presc_next;
    logic [SEC_W-1:0] sec_reg, sec_next;
    logic [SEC_W-1:0] lapv_reg, lapv_next;
    logic             hold_reg, hold_next;
    logic             blink_reg, blink_next;
    logic [SEC_W-1:0] cout_reg;
    logic [SEC_W-1:0] display;

    logic             tick;
    logic             free_run;
    logic [SEC_W:0]   sec_plus1;
    logic             target_hit;

    assign tick       = ((state_reg == RUN) || (state_reg == DONE)) &&
                        (presc_reg == (FULL_SEC - 32'd1));
    assign free_run   = (target == '0);
    assign sec_plus1  = {1'b0, sec_reg} + 1'b1;
    assign target_hit = !free_run && (sec_plus1 >= {1'b0, target});
    assign display    = hold_reg ? lapv_reg : sec_reg;

    // State and datapath registers; reset overrides any press or tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            sec_reg   <= '0;
            lapv_reg  <= '0;
            hold_reg  <= 1'b0;
            blink_reg <= 1'b0;
            cout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            sec_reg   <= sec_next;
            lapv_reg  <= lapv_next;
            hold_reg  <= hold_next;
            blink_reg <= blink_next;
            cout_reg  <= display;
        end
    end

    // Next-state, prescaler, seconds, blink and lap-hold decisions.
    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        sec_next   = sec_reg;
        lapv_next  = lapv_reg;
        hold_next  = hold_reg;
        blink_next = blink_reg;
        case (state_reg)
            IDLE: begin
                presc_next = '0;
                if (ss_press) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                presc_next = tick ? '0 : presc_reg + 32'd1;
                if (tick && target_hit) begin
                    // Reaching the target beats a simultaneous start_stop press.
                    sec_next   = target;
                    state_next = DONE;
                    blink_next = 1'b1;
                    hold_next  = 1'b0;
                end else begin
                    if (tick) begin
                        sec_next = sec_inc(sec_reg, free_run);
                    end
                    if (ss_press) begin
                        state_next = PAUSE;
                    end else if (lap_press) begin
                        hold_next = ~hold_reg;
                        lapv_next = sec_reg;
                    end
                end
            end
            PAUSE: begin
                if (ss_press) begin
                    state_next = RUN;
                end else if (lap_press) begin
                    hold_next = 1'b0;
                end
            end
            DONE: begin
                presc_next = tick ? '0 : presc_reg + 32'd1;
                if (ss_press) begin
                    state_next = IDLE;
                    sec_next   = '0;
                    presc_next = '0;
                    blink_next = 1'b0;
                end else if (tick) begin
                    blink_next = ~blink_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign c_out         = cout_reg;
    assign done          = (state_reg == DONE);
    assign blink_hr_sig  = blink_reg;
    assign blink_min_sig = blink_reg;
    assign blink_sec_sig = blink_reg;

endmodule

// File: tb/tb_count_up.sv
// Self-checking bench for count_up: directed scenarios plus random button
// and target activity against a cycle-level reference model, and a second
// instance with a one-cycle second for the day-wrap check.
`timescale 1ns/1ps
module tb_count_up;

    localparam int F = 4;
`ifdef COUNT_UP_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst, ss, lap;
    logic [16:0] target;
    logic [16:0] c_out;
    logic        done, bh, bm, bs;

    logic        rst_w, ss_w, lap_w;
    logic [16:0] target_w;
    logic [16:0] c_out_w;
    logic        done_w, bh_w, bm_w, bs_w;

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    count_up #(.FULL_SEC(32'd4)) dut (
        .clk(clk), .rst(rst), .start_stop(ss), .lap(lap), .target(target),
        .c_out(c_out), .done(done),
        .blink_hr_sig(bh), .blink_min_sig(bm), .blink_sec_sig(bs)
    );

    count_up #(.FULL_SEC(32'd1)) dut_w (
        .clk(clk), .rst(rst_w), .start_stop(ss_w), .lap(lap_w), .target(target_w),
        .c_out(c_out_w), .done(done_w),
        .blink_hr_sig(bh_w), .blink_min_sig(bm_w), .blink_sec_sig(bs_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int m_st, m_presc, m_sec, m_lapv, m_cout;
    bit m_hold, m_blink;
    bit hs1, hs2, hs3, hl1, hl2, hl3;   // pin samples from the last three edges

    function automatic void model_step();
        bit ssp, lpp, tick;
        int disp;
        if (rst) begin
            m_st = S_IDLE; m_presc = 0; m_sec = 0; m_lapv = 0; m_cout = 0;
            m_hold = 0; m_blink = 0;
            {hs1, hs2, hs3} = 3'b111;
            {hl1, hl2, hl3} = 3'b111;
            return;
        end
        // A press takes effect three edges after the pin is first seen low.
        ssp = hs3 & ~hs2;
        lpp = hl3 & ~hl2 & ~ssp & LAP_EN;
        hs3 = hs2; hs2 = hs1; hs1 = ss;
        hl3 = hl2; hl2 = hl1; hl1 = lap;
        disp = m_hold ? m_lapv : m_sec;
        tick = ((m_st == S_RUN) || (m_st == S_DONE)) && (m_presc == F - 1);
        if (m_st == S_RUN || m_st == S_DONE) m_presc = tick ? 0 : m_presc + 1;
        else if (m_st == S_IDLE) m_presc = 0;
        case (m_st)
            S_IDLE: if (ssp) m_st = S_RUN;
            S_RUN: begin
                if (tick && target != 0 && m_sec + 1 >= int'(target)) begin
                    m_sec = int'(target); m_st = S_DONE; m_blink = 1; m_hold = 0;
                end else begin
                    if (tick) m_sec = (target == 0) ? (m_sec + 1) % 86400 : m_sec + 1;
                    if (ssp) m_st = S_PAUSE;
                    else if (lpp) begin
                        if (!m_hold) m_lapv = disp;
                        m_hold = !m_hold;
                    end
                end
            end
            S_PAUSE: begin
                if (ssp) m_st = S_RUN;
                else if (lpp) m_hold = 0;
            end
            default: begin
                if (ssp) begin
                    m_st = S_IDLE; m_sec = 0; m_presc = 0; m_blink = 0;
                end else if (tick) m_blink = !m_blink;
            end
        endcase
        m_cout = disp;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_eq("c_out", {15'd0, c_out}, 32'(m_cout));
        check_eq("done", {31'd0, done}, (m_st == S_DONE) ? 32'd1 : 32'd0);
        check_eq("blink", {29'd0, bh, bm, bs}, m_blink ? 32'd7 : 32'd0);
    endtask

    task automatic press_ss();
        ss = 1'b0;
        repeat (4) step();
        ss = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!done && n < bound) begin step(); n++; end
        check_eq(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_cout(input string tag, input int val, input int bound);
        int n = 0;
        while (int'(c_out) != val && n < bound) begin step(); n++; end
        check_eq(tag, {15'd0, c_out}, 32'(val));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ss = 1'b1; lap = 1'b1; target = '0;
        rst_w = 1'b1; ss_w = 1'b1; lap_w = 1'b1; target_w = '0;
        fork
            begin : main_seq
                int e0;
                do_reset();
                check_eq("rst_cout", {15'd0, c_out}, 32'd0);
                check_eq("rst_done", {31'd0, done}, 32'd0);
                check_eq("rst_blink", {29'd0, bh, bm, bs}, 32'd0);

                // Count to target 3, then DONE with blinking.
                target = 17'd3;
                press_ss();
                wait_done("tgt_done", 60);
                check_eq("tgt_blink_entry", {29'd0, bh, bm, bs}, 32'd7);
                step();
                check_eq("tgt_cout", {15'd0, c_out}, 32'd3);
                repeat (3) step();
                check_eq("tgt_blink_toggle", {29'd0, bh, bm, bs}, 32'd0);
                repeat (4) step();
                check_eq("tgt_blink_toggle2", {29'd0, bh, bm, bs}, 32'd7);
                repeat (20) step();
                check_eq("tgt_cout_hold", {15'd0, c_out}, 32'd3);
                press_ss();
                repeat (3) step();
                check_eq("clr_done", {31'd0, done}, 32'd0);
                check_eq("clr_cout", {15'd0, c_out}, 32'd0);

                // Pause at 2 and resume.
                target = '0;
                press_ss();
                wait_cout("pause_reach1", 1, 40);
                press_ss();
                repeat (20) step();
                check_eq("pause_hold", {15'd0, c_out}, 32'd2);
                press_ss();
                wait_cout("resume_reach4", 4, 40);

                // Lap hold at 2, release at 5.
                do_reset();
                e0 = cyc + 3;
                press_ss();
                while (cyc < e0 + 6) step();
                lap = 1'b0; repeat (4) step(); lap = 1'b1;
                while (cyc < e0 + 15) step();
                check_eq("lap_hold", {15'd0, c_out}, LAP_EN ? 32'd2 : 32'd3);
                while (cyc < e0 + 18) step();
                lap = 1'b0; repeat (4) step(); lap = 1'b1;
                while (cyc < e0 + 24) step();
                check_eq("lap_release", {15'd0, c_out}, 32'd5);

                // Simultaneous start_stop and lap in RUN: pause, no hold.
                ss = 1'b0; lap = 1'b0;
                repeat (4) step();
                ss = 1'b1; lap = 1'b1;
                repeat (12) step();
                press_ss();
                repeat (12) step();

                // Reset mid-DONE with both buttons pressed.
                do_reset();
                target = 17'd1;
                press_ss();
                wait_done("rst_done_entry", 40);
                ss = 1'b0; lap = 1'b0;
                repeat (2) step();
                rst = 1'b1;
                step();
                check_eq("rstd_cout", {15'd0, c_out}, 32'd0);
                check_eq("rstd_done", {31'd0, done}, 32'd0);
                check_eq("rstd_blink", {29'd0, bh, bm, bs}, 32'd0);
                rst = 1'b0; ss = 1'b1; lap = 1'b1;
                repeat (6) step();
                check_eq("rstd_idle", {31'd0, done}, 32'd0);

                // Random buttons, targets and resets against the model.
                for (int i = 0; i < 3000; i++) begin
                    if ($urandom_range(0, 11) == 0) ss = ~ss;
                    if ($urandom_range(0, 13) == 0) lap = ~lap;
                    if ($urandom_range(0, 150) == 0) target = 17'($urandom_range(0, 6));
                    rst = ($urandom_range(0, 400) == 0);
                    step();
                end
                rst = 1'b0;
            end
            begin : wrap_seq
                // One-cycle second: seconds after edge n of the run equals n-3.
                repeat (2) @(posedge clk);
                #1;
                rst_w = 1'b0;
                ss_w  = 1'b0;
                for (int n = 1; n <= 86406; n++) begin
                    @(posedge clk);
                    #1;
                    if (n == 4) ss_w = 1'b1;
                    if (n >= 4) begin
                        check_eq("wrap_cout", {15'd0, c_out_w}, 32'((n - 4) % 86400));
                        check_eq("wrap_done", {31'd0, done_w}, 32'd0);
                    end
                    if (n == 86403) check_eq("wrap_max", {15'd0, c_out_w}, 32'd86399);
                    if (n == 86404) check_eq("wrap_zero", {15'd0, c_out_w}, 32'd0);
                end
            end
        join
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
